// File: rtl/data_sram_responder.sv
// Data SRAM slave: byte-writable word RAM plus confreg MMIO (LED, NUM, SWITCH, TIMER).
// Optional TIMER compare/interrupt enabled by defining DATA_SRAM_TIMER_CMP_EN.
module data_sram_responder #(
  parameter int ADDR_W = 16,
  parameter int LED_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  input  logic [7:0]        switch,
  output logic [LED_W-1:0]  led,
  output logic [31:0]       num,
  output logic              timer_irq
);

  localparam logic [15:0] OFF_LED     = 16'hf000;
  localparam logic [15:0] OFF_NUM     = 16'hf010;
  localparam logic [15:0] OFF_SWITCH  = 16'hf020;
  localparam logic [15:0] OFF_TIMER   = 16'he000;
  localparam logic [15:0] OFF_COMPARE = 16'he004;
  localparam logic [15:0] OFF_IRQ     = 16'he008;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    return res;
  endfunction

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] word_idx;
  logic [15:0]       offset;
  logic              conf_hit, rd_req, wr_req, conf_wr, ram_wr, timer_wr;
  logic [31:0]       led_ext, led_merged, timer, timer_inc, rd_data;
  logic [7:0]        sw_s1, sw_s2;

  assign word_idx  = data_sram_addr[ADDR_W+1:2];
  assign offset    = data_sram_addr[15:0];
  assign conf_hit  = (data_sram_addr[31:16] == 16'h1faf);
  assign rd_req    = data_sram_en && (data_sram_wen == 4'b0000);
  assign wr_req    = data_sram_en && (data_sram_wen != 4'b0000);
  assign conf_wr   = wr_req && conf_hit;
  assign ram_wr    = wr_req && !conf_hit;
  assign timer_wr  = conf_wr && (offset == OFF_TIMER);
  assign timer_inc = timer + 32'd1;
  assign led_ext   = 32'(led);
  assign led_merged = be_merge(led_ext, data_sram_wdata, data_sram_wen);

  // RAM has no reset; contents survive rst
  always_ff @(posedge clk) begin
    if (ram_wr)
      for (int i = 0; i < 4; i++)
        if (data_sram_wen[i]) mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
  end

`ifdef DATA_SRAM_TIMER_CMP_EN
  logic [31:0] compare;
  logic        irq_q;
  logic        cmp_wr;

  assign cmp_wr    = conf_wr && (offset == OFF_COMPARE);
  assign timer_irq = irq_q;

  // clear on COMPARE write has priority over a simultaneous match
  always_ff @(posedge clk) begin
    if (rst) begin
      compare <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (cmp_wr) compare <= be_merge(compare, data_sram_wdata, data_sram_wen);
      if (cmp_wr)
        irq_q <= 1'b0;
      else if (!timer_wr && (timer_inc == compare) && (compare != 32'd0))
        irq_q <= 1'b1;
    end
  end
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    if (conf_hit) begin
      case (offset)
        OFF_LED:     rd_data = led_ext;
        OFF_NUM:     rd_data = num;
        OFF_SWITCH:  rd_data = {24'b0, sw_s2};
        OFF_TIMER:   rd_data = timer;
`ifdef DATA_SRAM_TIMER_CMP_EN
        OFF_COMPARE: rd_data = compare;
        OFF_IRQ:     rd_data = {31'b0, irq_q};
`endif
        default:     rd_data = '0;
      endcase
    end else begin
      rd_data = mem[word_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_sram_rdata <= '0;
      led             <= '0;
      num             <= '0;
      timer           <= '0;
      sw_s1           <= '0;
      sw_s2           <= '0;
    end else begin
      sw_s1 <= switch;
      sw_s2 <= sw_s1;
      if (rd_req) data_sram_rdata <= rd_data;
      if (conf_wr && (offset == OFF_LED)) led <= led_merged[LED_W-1:0];
      if (conf_wr && (offset == OFF_NUM)) num <= be_merge(num, data_sram_wdata, data_sram_wen);
      if (timer_wr) timer <= be_merge(timer, data_sram_wdata, data_sram_wen);
      else          timer <= timer_inc;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder; expected rdata flows through a scoreboard queue.
module tb_data_sram_responder;

  logic        clk;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch;
  logic [15:0] led;
  logic [31:0] num;
  logic        timer_irq;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_exp;
  int          total  = 0;
  int          passed = 0;

  data_sram_responder #(.ADDR_W(16), .LED_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch          (switch),
    .led             (led),
    .num             (num),
    .timer_irq       (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // one bus cycle; the expected rdata after the edge is queued before the edge
  task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input string tag);
    exp_t e;
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    if (rst) last_exp = 32'h0;
    else if (en && wen == 4'b0000) last_exp = exp_rd;
    e.tag = tag;
    e.val = last_exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, data_sram_rdata, e.val);
    data_sram_en  = 1'b0;
    data_sram_wen = 4'b0000;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wen,
                    input string tag);
    step(1'b1, wen, addr, wdata, 32'h0, tag);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    step(1'b1, 4'b0000, addr, 32'h0, exp, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, tag);
  endtask

  initial begin
    rst             = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    switch          = 8'h00;
    last_exp        = 32'h0;
    #1;
    idle("reset_rdata0");
    idle("reset_rdata1");
    rst = 1'b0;
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_num", num, 32'h0);
    chk("reset_irq", 32'(timer_irq), 32'h0);

    wr(32'h0000_0100, 32'h1234_5678, 4'b1111, "ram_wr_full");
    rd(32'h0000_0100, 32'h1234_5678, "ram_rd_full");
    wr(32'h0000_0100, 32'hAAAA_AAAA, 4'b0100, "ram_wr_byte");
    rd(32'h0000_0100, 32'h12AA_5678, "ram_rd_byte_b2b");

    rd(32'h0000_0100, 32'h12AA_5678, "hold_rd");
    idle("hold_idle0");
    idle("hold_idle1");
    idle("hold_idle2");
    wr(32'h0000_0104, 32'hDEAD_BEEF, 4'b1111, "hold_wr");
    rd(32'h0004_0100, 32'h12AA_5678, "ram_alias");
    rd(32'h0000_0104, 32'hDEAD_BEEF, "ram_rd_104");
    rst = 1'b1;
    rd(32'h0000_0100, 32'h0, "rst_discard_rd");
    rst = 1'b0;
    rd(32'h0000_0100, 32'h12AA_5678, "ram_kept_rst");

    wr(32'h1faf_f000, 32'h0000_beef, 4'b1111, "led_wr");
    chk("led_out", 32'(led), 32'h0000_beef);
    rd(32'h1faf_f000, 32'h0000_beef, "led_rd");
    wr(32'h1faf_f010, 32'h1234_abcd, 4'b0011, "num_wr");
    chk("num_out", num, 32'h0000_abcd);
    rd(32'h1faf_f010, 32'h0000_abcd, "num_rd");

    switch = 8'h5a;
    idle("sw_wait0");
    idle("sw_wait1");
    rd(32'h1faf_f020, 32'h0000_005a, "sw_rd");
    wr(32'h1faf_f020, 32'hffff_ffff, 4'b1111, "sw_wr_ignored");
    rd(32'h1faf_f020, 32'h0000_005a, "sw_rd_again");
    rd(32'h1faf_f100, 32'h0, "unmapped_rd");

    wr(32'h1faf_e000, 32'hffff_fffe, 4'b1111, "timer_wr");
    rd(32'h1faf_e000, 32'hffff_fffe, "timer_n1");
    rd(32'h1faf_e000, 32'hffff_ffff, "timer_n2");
    rd(32'h1faf_e000, 32'h0000_0000, "timer_wrap");

`ifdef DATA_SRAM_TIMER_CMP_EN
    wr(32'h1faf_e004, 32'd20, 4'b1111, "cmp_wr");
    wr(32'h1faf_e000, 32'd10, 4'b1111, "timer_wr10");
    for (int i = 1; i <= 12; i++) begin
      idle("irq_wait");
      chk("irq_rise", 32'(timer_irq), (i >= 10) ? 32'h1 : 32'h0);
    end
    rd(32'h1faf_e008, 32'h1, "irq_rd_set");
    wr(32'h1faf_e004, 32'd0, 4'b1111, "cmp_clear");
    chk("irq_cleared", 32'(timer_irq), 32'h0);
    rd(32'h1faf_e008, 32'h0, "irq_rd_clr");
`else
    wr(32'h1faf_e004, 32'h0000_0055, 4'b1111, "e004_wr");
    rd(32'h1faf_e004, 32'h0, "e004_rd");
    rd(32'h1faf_e008, 32'h0, "e008_rd");
    for (int i = 0; i < 4; i++) begin
      idle("irq_idle");
      chk("irq_tied0", 32'(timer_irq), 32'h0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
